sobel_window_buffer: RTL and testbench

//  Converts the raster pixel stream read from image_rom into a 3x3 neighbourhood window.

---
 rtl/sobel_window_buffer.sv | 152 +++++++++++++++
 tb/tb_sobel_window_buffer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_buffer.sv
`default_nettype none
// sobel_window_buffer: turns a raster pixel stream into 3x3 windows with centre coordinates.
// Define SOBEL_WIN_FRAME_CHECK_EN to enable the sticky frame_err framing check.
module sobel_window_buffer #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic                  sof_in,
  input  logic [DATA_W-1:0]     pixel_in,
  output logic                  win_valid,
  output logic [9*DATA_W-1:0]   win,
  output logic [8:0]            ctr_x,
  output logic [7:0]            ctr_y,
  output logic                  frame_done,
  output logic                  frame_err
);

  localparam int         AW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [8:0] COL_LAST = 9'(IMG_WIDTH - 1);
  localparam logic [7:0] ROW_LAST = 8'(IMG_HEIGHT - 1);

  logic [8:0] col_q, col_d, pos_col;
  logic [7:0] row_q, row_d, pos_row;

  // lb0 holds row y-1, lb1 holds row y-2; deliberately not reset.
  logic [DATA_W-1:0] lb0_mem [IMG_WIDTH];
  logic [DATA_W-1:0] lb1_mem [IMG_WIDTH];
  logic [AW-1:0]     lb_idx;
  logic [DATA_W-1:0] lb_a, lb_b;

  // [row][col], row 0 = oldest line, col 2 = newest column; flattens MSB-first as p00..p22.
  logic [0:2][0:2][DATA_W-1:0] sh_q, sh_d;

  logic                win_valid_q, win_valid_d;
  logic [9*DATA_W-1:0] win_q, win_d;
  logic [8:0]          ctr_x_q, ctr_x_d;
  logic [7:0]          ctr_y_q, ctr_y_d;
  logic                frame_done_q, frame_done_d;
  logic                emit;

  assign pos_col = sof_in ? 9'd0 : col_q;
  assign pos_row = sof_in ? 8'd0 : row_q;
  assign lb_idx  = pos_col[AW-1:0];
  assign lb_a    = lb1_mem[lb_idx];
  assign lb_b    = lb0_mem[lb_idx];
  assign emit    = valid_in && (pos_col >= 9'd2) && (pos_row >= 8'd2);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (valid_in) begin
      if (pos_col == COL_LAST) begin
        col_d = 9'd0;
        row_d = (pos_row == ROW_LAST) ? 8'd0 : pos_row + 8'd1;
      end else begin
        col_d = pos_col + 9'd1;
        row_d = pos_row;
      end
    end
  end

  always_comb begin
    sh_d = sh_q;
    if (valid_in) begin
      for (int r = 0; r < 3; r++) begin
        sh_d[r][0] = sh_q[r][1];
        sh_d[r][1] = sh_q[r][2];
      end
      sh_d[0][2] = lb_a;
      sh_d[1][2] = lb_b;
      sh_d[2][2] = pixel_in;
    end
  end

  always_comb begin
    win_valid_d  = emit;
    win_d        = emit ? sh_d : win_q;
    ctr_x_d      = emit ? pos_col - 9'd1 : ctr_x_q;
    ctr_y_d      = emit ? pos_row - 8'd1 : ctr_y_q;
    frame_done_d = valid_in && (pos_col == COL_LAST) && (pos_row == ROW_LAST);
  end

  always_ff @(posedge clk) begin
    if (valid_in) begin
      lb0_mem[lb_idx] <= pixel_in;
      lb1_mem[lb_idx] <= lb_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= 9'd0;
      row_q        <= 8'd0;
      sh_q         <= '0;
      win_valid_q  <= 1'b0;
      win_q        <= '0;
      ctr_x_q      <= 9'd0;
      ctr_y_q      <= 8'd0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      sh_q         <= sh_d;
      win_valid_q  <= win_valid_d;
      win_q        <= win_d;
      ctr_x_q      <= ctr_x_d;
      ctr_y_q      <= ctr_y_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign win_valid  = win_valid_q;
  assign win        = win_q;
  assign ctr_x      = ctr_x_q;
  assign ctr_y      = ctr_y_q;
  assign frame_done = frame_done_q;

`ifdef SOBEL_WIN_FRAME_CHECK_EN
  logic started_q, started_d;
  logic frame_err_q, frame_err_d;

  // Judged on the raw counters: the offending pixel is still resynchronised normally.
  always_comb begin
    started_d   = started_q | valid_in;
    frame_err_d = frame_err_q;
    if (valid_in) begin
      if (sof_in && ((col_q != 9'd0) || (row_q != 8'd0))) frame_err_d = 1'b1;
      if (!sof_in && (col_q == 9'd0) && (row_q == 8'd0) && started_q) frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      started_q   <= started_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_buffer.sv
`default_nettype none
// Directed bench for sobel_window_buffer at 8x6 with pixel = 16*y + x.
module tb_sobel_window_buffer;
  localparam int W    = 8;
  localparam int H    = 6;
  localparam int NWIN = (W - 2) * (H - 2);
`ifdef SOBEL_WIN_FRAME_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic        sof_in = 1'b0;
  logic [7:0]  pixel_in = 8'd0;
  logic        win_valid;
  logic [71:0] win;
  logic [8:0]  ctr_x;
  logic [7:0]  ctr_y;
  logic        frame_done;
  logic        frame_err;

  sobel_window_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .sof_in(sof_in), .pixel_in(pixel_in),
    .win_valid(win_valid), .win(win), .ctr_x(ctr_x), .ctr_y(ctr_y),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [71:0] cap_win[$];
  int          cap_x[$];
  int          cap_y[$];
  int          done_cnt = 0;
  bit          gap_bad = 1'b0;

  always @(negedge clk) begin
    if (win_valid === 1'b1) begin
      cap_win.push_back(win);
      cap_x.push_back(int'(ctr_x));
      cap_y.push_back(int'(ctr_y));
    end
    if (frame_done === 1'b1) done_cnt++;
  end

  function automatic logic [71:0] exp_win(input int cx, input int cy);
    logic [71:0] w = '0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        w = {w[63:0], 8'(16 * (cy + dy) + (cx + dx))};
    return w;
  endfunction

  task automatic drive(input bit v, input bit sof, input logic [7:0] pix);
    @(negedge clk);
    valid_in = v;
    sof_in   = sof;
    pixel_in = pix;
    @(posedge clk);
    #1;
    if (!v && win_valid !== 1'b0) gap_bad = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    valid_in = 1'b0;
    sof_in   = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cap_win.delete();
    cap_x.delete();
    cap_y.delete();
    done_cnt = 0;
    gap_bad  = 1'b0;
  endtask

  task automatic feed_frame(input int max_gap, input string tag);
    int g;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (max_gap > 0) begin
          g = int'($urandom_range(0, max_gap));
          repeat (g) drive(1'b0, 1'b0, 8'd0);
        end
        drive(1'b1, (x == 0) && (y == 0), 8'(16 * y + x));
      end
    end
    total++;
    if (frame_done !== 1'b1) begin
      bad++;
      $display("FAIL %s_frame_done_timing: got %b want 1", tag, frame_done);
    end
  endtask

  task automatic check_frame(input int base, input int exp_size, input string tag);
    total++;
    if (cap_win.size() != exp_size) begin
      bad++;
      $display("FAIL %s_win_count: got %0d want %0d", tag, cap_win.size(), exp_size);
    end
    for (int k = 0; k < NWIN; k++) begin
      if (base + k < cap_win.size()) begin
        int cx = 1 + (k % (W - 2));
        int cy = 1 + (k / (W - 2));
        total++;
        if (cap_win[base+k] !== exp_win(cx, cy) || cap_x[base+k] != cx || cap_y[base+k] != cy) begin
          bad++;
          $display("FAIL %s_win%0d: got ctr=(%0d,%0d) win=%h want ctr=(%0d,%0d) win=%h", tag, k,
                   cap_x[base+k], cap_y[base+k], cap_win[base+k], cx, cy, exp_win(cx, cy));
        end
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    total++; if (win_valid !== 1'b0) begin bad++; $display("FAIL rst_win_valid: got %b want 0", win_valid); end
    total++; if (win !== 72'd0) begin bad++; $display("FAIL rst_win: got %h want 0", win); end
    total++; if (ctr_x !== 9'd0 || ctr_y !== 8'd0) begin bad++; $display("FAIL rst_ctr: got (%0d,%0d) want (0,0)", ctr_x, ctr_y); end
    total++; if (frame_done !== 1'b0 || frame_err !== 1'b0) begin bad++; $display("FAIL rst_flags: got done=%b err=%b want 0 0", frame_done, frame_err); end
  endtask

  task automatic test_first_window();
    bit early = 1'b0;
    apply_reset();
    for (int i = 0; i < 2 * W + 3; i++) begin
      if (win_valid !== 1'b0) early = 1'b1;
      drive(1'b1, i == 0, 8'(16 * (i / W) + (i % W)));
    end
    total++; if (early) begin bad++; $display("FAIL first_early_valid: got 1 want 0"); end
    total++; if (win_valid !== 1'b1) begin bad++; $display("FAIL first_valid: got %b want 1", win_valid); end
    total++; if (win !== 72'h00_01_02_10_11_12_20_21_22) begin bad++; $display("FAIL first_win: got %h want 000102101112202122", win); end
    total++; if (ctr_x !== 9'd1 || ctr_y !== 8'd1) begin bad++; $display("FAIL first_ctr: got (%0d,%0d) want (1,1)", ctr_x, ctr_y); end
    idle(2);
    total++; if (win_valid !== 1'b0 || win !== 72'h00_01_02_10_11_12_20_21_22) begin
      bad++; $display("FAIL first_hold: got valid=%b win=%h want 0 000102101112202122", win_valid, win);
    end
  endtask

  task automatic test_full_frame();
    apply_reset();
    feed_frame(0, "full");
    idle(2);
    check_frame(0, NWIN, "full");
    total++; if (cap_x.size() == 0 || cap_x[$] != 6 || cap_y[$] != 4) begin
      bad++; $display("FAIL full_last_ctr: got (%0d,%0d) want (6,4)",
                      cap_x.size() ? cap_x[$] : -1, cap_y.size() ? cap_y[$] : -1);
    end
    total++; if (cap_win.size() == 0 || cap_win[$][7:0] !== 8'h57) begin
      bad++; $display("FAIL full_last_p22: got %h want 57", cap_win.size() ? cap_win[$][7:0] : 8'hxx);
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL full_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_gaps();
    apply_reset();
    feed_frame(3, "gaps");
    idle(2);
    check_frame(0, NWIN, "gaps");
    total++; if (gap_bad) begin bad++; $display("FAIL gaps_valid_in_gap: got 1 want 0"); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL gaps_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_short_frame();
    apply_reset();
    for (int i = 0; i < 20; i++) drive(1'b1, i == 0, 8'(16 * (i / W) + (i % W)));
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL short_err_before: got %b want 0", frame_err); end
    feed_frame(0, "short");
    idle(2);
    // The partial frame legitimately produced centres (1,1) and (2,1) before the resync.
    check_frame(2, 2 + NWIN, "short");
    total++; if (frame_err !== EXP_ERR) begin bad++; $display("FAIL short_err: got %b want %b", frame_err, EXP_ERR); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 3 * W + 5; i++) drive(1'b1, i == 0, 8'(16 * (i / W) + (i % W)));
    valid_in = 1'b0;
    total++; if (ctr_x !== 9'd3 || ctr_y !== 8'd2) begin bad++; $display("FAIL mid_pre_ctr: got (%0d,%0d) want (3,2)", ctr_x, ctr_y); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (win_valid !== 1'b0 || win !== 72'd0 || ctr_x !== 9'd0 || ctr_y !== 8'd0 || frame_err !== 1'b0) begin
      bad++; $display("FAIL mid_async_rst: got v=%b win=%h ctr=(%0d,%0d) err=%b want all 0",
                      win_valid, win, ctr_x, ctr_y, frame_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cap_win.delete(); cap_x.delete(); cap_y.delete();
    done_cnt = 0;
    feed_frame(0, "mid");
    idle(2);
    check_frame(0, NWIN, "mid");
  endtask

  task automatic test_back_to_back();
    apply_reset();
    feed_frame(0, "b2b_f1");
    feed_frame(0, "b2b_f2");
    idle(2);
    check_frame(0, 2 * NWIN, "b2b_f1");
    check_frame(NWIN, 2 * NWIN, "b2b_f2");
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL b2b_err: got %b want 0", frame_err); end
    total++; if (done_cnt != 2) begin bad++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_first_window();
    test_full_frame();
    test_gaps();
    test_short_frame();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
